// File: rtl/time_display_scanner.sv
// Six-digit multiplexed common-anode 7-segment driver for hh:mm:ss.
// Scans one digit per prescaler period, blanks for one cycle between digits, and latches a per-frame snapshot.
module time_display_scanner #(
    parameter int CLK_FREQ_HZ     = 50_000,
    parameter int SCAN_FREQ_HZ    = 1_000,
    parameter bit HOUR_BLANK_ZERO = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] in_hour,
    input  logic [5:0] in_min,
    input  logic [5:0] in_sec,
    input  logic       colon_en,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int DIV = CLK_FREQ_HZ / SCAN_FREQ_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    function automatic logic [3:0] bcd_tens(input logic [5:0] v);
        logic [5:0] q;
        q = v / 6'd10;
        return q[3:0];
    endfunction

    function automatic logic [3:0] bcd_units(input logic [5:0] v);
        logic [5:0] r;
        r = v % 6'd10;
        return r[3:0];
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [PW-1:0] prescaler;
    logic [2:0]    idx;
    logic [2:0]    idx_next;
    logic          tick;
    logic          vld_p1;
    logic [4:0]    snap_hour;
    logic [5:0]    snap_min;
    logic [5:0]    snap_sec;
    logic [5:0]    hour6;
    logic [3:0]    digit;
    logic [5:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    assign tick     = (prescaler == LAST);
    assign idx_next = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    assign hour6    = {1'b0, snap_hour};

    always_comb begin
        digit    = 4'd0;
        an_next  = ~(6'b000001 << idx);
        dp_next  = ~(colon_en && (idx == 3'd2 || idx == 3'd4));
        case (idx)
            3'd0:    digit = bcd_units(snap_sec);
            3'd1:    digit = bcd_tens(snap_sec);
            3'd2:    digit = bcd_units(snap_min);
            3'd3:    digit = bcd_tens(snap_min);
            3'd4:    digit = bcd_units(hour6);
            3'd5:    digit = bcd_tens(hour6);
            default: digit = 4'd0;
        endcase
        seg_next = seg_decode(digit);
        // Leading-zero suppression keeps the anode driven so digit timing is unchanged.
        if (HOUR_BLANK_ZERO && idx == 3'd5 && bcd_tens(hour6) == 4'd0)
            seg_next = 7'h7F;
    end

    // Stage p0: prescaler tick blanks outputs and advances idx; stage p1 (vld_p1): drive the new digit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            idx       <= 3'd5;
            vld_p1    <= 1'b0;
            snap_hour <= '0;
            snap_min  <= '0;
            snap_sec  <= '0;
            an        <= 6'h3F;
            seg       <= 7'h7F;
            dp        <= 1'b1;
        end else begin
            vld_p1 <= 1'b0;
            if (tick) begin
                prescaler <= '0;
                idx       <= idx_next;
                vld_p1    <= 1'b1;
                an        <= 6'h3F;
                seg       <= 7'h7F;
                dp        <= 1'b1;
                if (idx_next == 3'd0) begin
                    snap_hour <= in_hour;
                    snap_min  <= in_min;
                    snap_sec  <= in_sec;
                end
            end else begin
                prescaler <= prescaler + PW'(1);
                if (vld_p1) begin
                    an  <= an_next;
                    seg <= seg_next;
                    dp  <= dp_next;
                end
            end
        end
    end

endmodule
